// File: rtl/prog_full_pkg.sv
// Shared mode encodings and the active/shadow configuration record for prog_full_pattern_gen.
// No logic, types and constants only.
package prog_full_pkg;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_PULSE = 2'd1;
    localparam logic [1:0] MODE_DUTY  = 2'd2;
    localparam logic [1:0] MODE_LATCH = 2'd3;

    // The record is sized here, so the top-level CNT_W must equal PFG_CNT_W.
    localparam int PFG_CNT_W = 13;

    typedef struct packed {
        logic [1:0]           mode;
        logic [PFG_CNT_W-1:0] period;
        logic [PFG_CNT_W-1:0] high;
    } pfg_cfg_t;

endpackage

// File: rtl/pfg_period_counter.sv
// Period counter: combinational wrap and count_next, with period_tick registered one cycle after a wrap.
// There is no backpressure. The counter freezes while enable_i=0, and clear_i forces it to zero.
module pfg_period_counter #(
    parameter int CNT_W = 13
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] period_i,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] count_next_o,
    output logic             wrap_o,
    output logic             tick_o
);

    logic [CNT_W-1:0] count_q, count_d;
    logic             tick_q;

    assign wrap_o = enable_i && (count_q == period_i);

    always_comb begin
        count_d = count_q;
        if (clear_i || wrap_o) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            tick_q  <= wrap_o;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign tick_o       = tick_q;

endmodule

// File: rtl/prog_full_pattern_gen.sv
// Programmable-full pattern generator with OFF, PULSE, DUTY and LATCH modes. All outputs are registered.
// Config uses valid/ready: cfg_ready stays low while a shadow config waits for a period boundary.
module prog_full_pattern_gen #(
    parameter int CNT_W      = prog_full_pkg::PFG_CNT_W,
    parameter int DEF_PERIOD = 8191,
    parameter int DEF_MODE   = 1,
    parameter int DEF_HIGH   = 1,
    parameter int EVT_W      = 16
) (
    input  logic             prg_clk,
    input  logic             prg_rst,
    input  logic             enable,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [1:0]       cfg_mode,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic             latch_clr,
    output logic             prog_full,
    output logic             period_tick,
    output logic [EVT_W-1:0] evt_count
);
    import prog_full_pkg::*;

    localparam pfg_cfg_t DEF_CFG = '{
        mode:   2'(DEF_MODE),
        period: CNT_W'(DEF_PERIOD),
        high:   CNT_W'(DEF_HIGH)
    };

    pfg_cfg_t         act_q, act_d, shd_q, shd_d, eff;
    logic             pend_q, pend_d;
    logic             pf_q, pf_d;
    logic [EVT_W-1:0] evt_q, evt_d;
    logic             capture, apply, wrap, tick;
    logic [CNT_W-1:0] count, count_next;

    pfg_period_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk_i        (prg_clk),
        .rst_i        (prg_rst),
        .enable_i     (enable),
        .clear_i      (apply),
        .period_i     (act_q.period),
        .count_o      (count),
        .count_next_o (count_next),
        .wrap_o       (wrap),
        .tick_o       (tick)
    );

    // A stalled generator in OFF would never wrap usefully, so it accepts the new config immediately.
    assign capture = cfg_valid && !pend_q;
    assign apply   = pend_q && (wrap || (act_q.mode == MODE_OFF));
    assign eff     = apply ? shd_q : act_q;

    always_comb begin
        shd_d  = shd_q;
        act_d  = act_q;
        pend_d = pend_q;
        if (capture) begin
            shd_d  = '{mode: cfg_mode, period: cfg_period, high: cfg_high};
            pend_d = 1'b1;
        end
        if (apply) begin
            act_d  = shd_q;
            pend_d = 1'b0;
        end
    end

    // The new mode is evaluated from the apply cycle onward, and a latched flag is dropped on apply.
    always_comb begin
        pf_d = pf_q;
        if (enable) begin
            case (eff.mode)
                MODE_OFF:   pf_d = 1'b0;
                MODE_PULSE: pf_d = wrap;
                MODE_DUTY:  pf_d = (count_next < eff.high);
                MODE_LATCH: pf_d = wrap || (pf_q && !latch_clr && !apply);
                default:    pf_d = 1'b0;
            endcase
        end
    end

    always_comb begin
        evt_d = evt_q;
        if (pf_d && !pf_q && (evt_q != {EVT_W{1'b1}})) begin
            evt_d = evt_q + EVT_W'(1);
        end
    end

    always_ff @(posedge prg_clk or posedge prg_rst) begin
        if (prg_rst) begin
            act_q  <= DEF_CFG;
            shd_q  <= '0;
            pend_q <= 1'b0;
            pf_q   <= 1'b0;
            evt_q  <= '0;
        end else begin
            act_q  <= act_d;
            shd_q  <= shd_d;
            pend_q <= pend_d;
            pf_q   <= pf_d;
            evt_q  <= evt_d;
        end
    end

    assign cfg_ready   = !pend_q;
    assign prog_full   = pf_q;
    assign period_tick = tick;
    assign evt_count   = evt_q;

    // The current count is kept on the submodule interface for probing but is not needed here.
    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: doc/prog_full_pattern_gen.md
Name: prog_full_pattern_gen

Overview:
- Parametrised generator of the programmable-full flag that throttles the Xillybus FIFO producer during loopback and stress tests.
- Replaces the fixed 8192-cycle single-pulse generator with four runtime modes: OFF, PULSE, DUTY and LATCH.
- Period, high time and mode are set through a valid/ready handshake and take effect only on a period boundary, so pattern changes are glitch-free.
- Also provides a period tick and a saturating count of prog_full assertions for the test harness.

Parameters:
- CNT_W, 13, width of the period counter and of the period/high-time fields.
- DEF_PERIOD, 8191, terminal count after reset; the period is DEF_PERIOD+1 cycles.
- DEF_MODE, 1, mode after reset (1 = PULSE, which keeps the legacy 8192-cycle behaviour).
- DEF_HIGH, 1, DUTY high time after reset, in cycles.
- EVT_W, 16, width of evt_count.

Ports:
- prg_clk, in, 1, the only clock.
- prg_rst, in, 1, reset; asynchronous, active-high.
- enable, in, 1, 1 = counter advances; 0 = counter and prog_full frozen.
- cfg_valid, in, 1, a new configuration is offered.
- cfg_ready, out, 1, the shadow configuration register is free.
- cfg_mode, in, 2, 0 OFF, 1 PULSE, 2 DUTY, 3 LATCH.
- cfg_period, in, CNT_W, terminal count; the period is cfg_period+1 cycles.
- cfg_high, in, CNT_W, DUTY high time in cycles.
- latch_clr, in, 1, clears prog_full in LATCH mode.
- prog_full, out, 1, the generated flag (registered).
- period_tick, out, 1, single-cycle strobe marking a wrap.
- evt_count, out, EVT_W, number of prog_full rising edges, saturating.

Behaviour:
- Reset (prg_rst=1, asynchronous, any time):
  - count=0; active config = {DEF_MODE, DEF_PERIOD, DEF_HIGH}; pending flag cleared and shadow discarded.
  - Outputs: prog_full=0, period_tick=0, evt_count=0, cfg_ready=1.
- Counter:
  - wrap = enable && (count == period_r).
  - On wrap, count becomes 0; otherwise, when enable=1, count increments by 1.
  - When enable=0, count, prog_full and evt_count hold, and period_tick=0.
  - period_tick is registered: it is 1 in the cycle after a wrap.
- Mode behaviour (all registered, all evaluated only while enable=1):
  - OFF: prog_full=0. The counter and period_tick still run.
  - PULSE: prog_full <= wrap. With defaults this gives one 1-cycle pulse every 8192 cycles, coincident with count==0.
  - DUTY: prog_full <= (count_next < high_r), so prog_full==1 exactly while count < high_r.
    - high_r=0 means prog_full is never asserted.
    - high_r > period_r means prog_full is always asserted.
  - LATCH: prog_full is set by wrap and cleared by latch_clr. If both occur in the same cycle, set wins. latch_clr is ignored in all other modes.
- Config handshake:
  - A transfer occurs when cfg_valid && cfg_ready. The fields are captured into the shadow register, pending is set to 1, and cfg_ready is 0 from the next cycle.
  - Apply event: the first wrap while pending=1, or the cycle after capture if the active mode is OFF.
  - On apply: shadow is copied to active, count is set to 0, pending is cleared, and cfg_ready returns to 1 in the next cycle.
  - prog_full is evaluated under the new mode from the apply cycle onward, and any latched state is dropped.
- cfg_period=0 gives a 1-cycle period:
  - PULSE: prog_full stays 1 continuously.
  - period_tick stays 1 continuously.
- evt_count:
  - Increments when prog_full goes 0→1 (registered compare against the previous value).
  - Saturates at 2^EVT_W−1.
  - Is cleared only by reset.
- A capture and an apply in the same cycle cannot occur, because cfg_ready=0 while pending=1.

Decomposition:
- Shared package prog_full_pkg holds:
  - mode encoding constants MODE_OFF/PULSE/DUTY/LATCH;
  - the configuration struct type {mode, period, high}.
- One sub-module, pfg_period_counter, provides the counter, wrap detection and period_tick. Mode logic, the handshake and evt_count stay in the top level.

Test Plan:
- Defaults, enable=1, 20000 cycles → prog_full pulses at cycles 8192 and 16384 after reset release, each 1 cycle wide; evt_count=2.
- Write {DUTY, period=9, high=3} mid-period → cfg_ready=0 until the next wrap. After that, the pattern repeats as 3 cycles high, 7 low; period_tick appears every 10 cycles.
- LATCH, period=4 → prog_full set at the first wrap and held. latch_clr at the same cycle as the next wrap → prog_full stays 1. latch_clr one cycle later → prog_full=0.
- enable dropped for 5 cycles in DUTY → count and prog_full frozen, no period_tick; the sequence resumes unchanged.
- OFF active, write {PULSE, period=0} → applied the next cycle; prog_full=1 continuously; evt_count increments once.
- Assert prg_rst mid-DUTY with pending config → all outputs return to reset values at once; after release, the block resumes the default 8192-cycle pulse and the pending config is not applied.
